// File: rtl/id_ex_stall_ctrl_pkg.sv
// Shared types and constants for the ID/EX stall and flush controller.
// Optional build macro: STALL_PERF_CNT_EN (stall-cause performance counters).
package id_ex_stall_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned DIV_LAT_DEF = 33;
  localparam int unsigned PERF_CNT_W  = 32;

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_DIV_WAIT    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT    = 2'd2;
  localparam logic [1:0] ST_MEM_DISCARD = 2'd3;

  // Pipeline-register control bundle, MSB first in this order.
  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_wen;
    logic id_ex_flush;
    logic ex_mem_wen;
    logic bp_flush;
    logic div_done;
    logic div_cancel;
  } stall_ctl_t;

endpackage

// File: rtl/id_ex_stall_ctrl_if.sv
// Hazard inputs and pipeline-register controls between the core and the stall controller.
// Optional build macro: STALL_PERF_CNT_EN adds the stall-cause counter outputs.
interface id_ex_stall_ctrl_if;
  import id_ex_stall_ctrl_pkg::*;

  logic [REG_W-1:0] id_reg_j;
  logic [REG_W-1:0] id_reg_k;
  logic [REG_W-1:0] id_reg_d;
  logic             id_reg_j_ren;
  logic             id_reg_k_ren;
  logic             id_reg_d_ren;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_reg_d;
  logic             ex_div_start;
  logic             ex_br_mispred;
  logic             mem_req;
  logic             mem_addr_ok;
  logic             mem_data_ok;
  logic             wb_flush;

  logic pc_wen;
  logic if_id_wen;
  logic if_id_flush;
  logic id_ex_wen;
  logic id_ex_flush;
  logic ex_mem_wen;
  logic bp_flush;
  logic div_done;
  logic div_cancel;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] lu_stall_cnt;
  logic [PERF_CNT_W-1:0] div_stall_cnt;
  logic [PERF_CNT_W-1:0] mem_stall_cnt;

  modport master (
    output id_reg_j, id_reg_k, id_reg_d, id_reg_j_ren, id_reg_k_ren, id_reg_d_ren,
           ex_is_load, ex_reg_d, ex_div_start, ex_br_mispred,
           mem_req, mem_addr_ok, mem_data_ok, wb_flush,
    input  pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen,
           bp_flush, div_done, div_cancel, lu_stall_cnt, div_stall_cnt, mem_stall_cnt
  );

  modport slave (
    input  id_reg_j, id_reg_k, id_reg_d, id_reg_j_ren, id_reg_k_ren, id_reg_d_ren,
           ex_is_load, ex_reg_d, ex_div_start, ex_br_mispred,
           mem_req, mem_addr_ok, mem_data_ok, wb_flush,
    output pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen,
           bp_flush, div_done, div_cancel, lu_stall_cnt, div_stall_cnt, mem_stall_cnt
  );
`else
  modport master (
    output id_reg_j, id_reg_k, id_reg_d, id_reg_j_ren, id_reg_k_ren, id_reg_d_ren,
           ex_is_load, ex_reg_d, ex_div_start, ex_br_mispred,
           mem_req, mem_addr_ok, mem_data_ok, wb_flush,
    input  pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen,
           bp_flush, div_done, div_cancel
  );

  modport slave (
    input  id_reg_j, id_reg_k, id_reg_d, id_reg_j_ren, id_reg_k_ren, id_reg_d_ren,
           ex_is_load, ex_reg_d, ex_div_start, ex_br_mispred,
           mem_req, mem_addr_ok, mem_data_ok, wb_flush,
    output pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, ex_mem_wen,
           bp_flush, div_done, div_cancel
  );
`endif

endinterface

// File: rtl/id_ex_stall_ctrl_hazard_detect.sv
// Load-use comparator: an EX load whose destination feeds any enabled ID source.
module id_ex_hazard_detect
  import id_ex_stall_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_id_reg_j,
  input  logic [REG_W-1:0] i_id_reg_k,
  input  logic [REG_W-1:0] i_id_reg_d,
  input  logic             i_id_reg_j_ren,
  input  logic             i_id_reg_k_ren,
  input  logic             i_id_reg_d_ren,
  input  logic             i_ex_is_load,
  input  logic [REG_W-1:0] i_ex_reg_d,
  output logic             o_lu_hazard_c
);

  logic w_j_hit;
  logic w_k_hit;
  logic w_d_hit;

  assign w_j_hit = i_id_reg_j_ren && (i_id_reg_j == i_ex_reg_d);
  assign w_k_hit = i_id_reg_k_ren && (i_id_reg_k == i_ex_reg_d);
  assign w_d_hit = i_id_reg_d_ren && (i_id_reg_d == i_ex_reg_d);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign o_lu_hazard_c = i_ex_is_load && (i_ex_reg_d != '0) && (w_j_hit || w_k_hit || w_d_hit);

endmodule

// File: rtl/id_ex_stall_ctrl.sv
// Pipeline hazard/flush controller: load-use bubble, divider and data-bus freezes, redirects.
// Optional build macro: STALL_PERF_CNT_EN adds saturating per-cause stall counters.
module id_ex_stall_ctrl
  import id_ex_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEF,
  parameter int unsigned CNT_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_stall_ctrl_if.slave     io_stall
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lu_hazard;
  logic             w_mem_stall;
  stall_ctl_t       w_ctl;

  id_ex_hazard_detect u_hazard_detect (
    .i_id_reg_j     (io_stall.id_reg_j),
    .i_id_reg_k     (io_stall.id_reg_k),
    .i_id_reg_d     (io_stall.id_reg_d),
    .i_id_reg_j_ren (io_stall.id_reg_j_ren),
    .i_id_reg_k_ren (io_stall.id_reg_k_ren),
    .i_id_reg_d_ren (io_stall.id_reg_d_ren),
    .i_ex_is_load   (io_stall.ex_is_load),
    .i_ex_reg_d     (io_stall.ex_reg_d),
    .o_lu_hazard_c  (w_lu_hazard)
  );

  assign w_mem_stall = io_stall.mem_req && !(io_stall.mem_addr_ok && io_stall.mem_data_ok);

  // State and divider counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and pipeline controls; priority wb_flush > mem freeze > mispredict > div > load-use.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_ctl.pc_wen      = 1'b1;
    w_ctl.if_id_wen   = 1'b1;
    w_ctl.if_id_flush = 1'b0;
    w_ctl.id_ex_wen   = 1'b1;
    w_ctl.id_ex_flush = 1'b0;
    w_ctl.ex_mem_wen  = 1'b1;
    w_ctl.bp_flush    = 1'b0;
    w_ctl.div_done    = 1'b0;
    w_ctl.div_cancel  = 1'b0;

    if (io_stall.wb_flush) begin
      w_ctl.if_id_flush = 1'b1;
      w_ctl.id_ex_flush = 1'b1;
      case (r_state)
        ST_DIV_WAIT: begin
          w_ctl.div_cancel = 1'b1;
          w_state_nxt      = ST_RUN;
          w_cnt_nxt        = '0;
        end
        ST_MEM_WAIT, ST_MEM_DISCARD: begin
          w_state_nxt = io_stall.mem_data_ok ? ST_RUN : ST_MEM_DISCARD;
        end
        default: begin
          // An accepted request still owes a response that must be dropped.
          w_state_nxt = (w_mem_stall && io_stall.mem_addr_ok) ? ST_MEM_DISCARD : ST_RUN;
        end
      endcase
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            w_ctl.pc_wen     = 1'b0;
            w_ctl.if_id_wen  = 1'b0;
            w_ctl.id_ex_wen  = 1'b0;
            w_ctl.ex_mem_wen = 1'b0;
            w_state_nxt      = ST_MEM_WAIT;
          end else if (io_stall.ex_br_mispred) begin
            w_ctl.if_id_flush = 1'b1;
            w_ctl.id_ex_flush = 1'b1;
            w_ctl.bp_flush    = 1'b1;
          end else if (io_stall.ex_div_start) begin
            w_ctl.pc_wen     = 1'b0;
            w_ctl.if_id_wen  = 1'b0;
            w_ctl.id_ex_wen  = 1'b0;
            w_ctl.ex_mem_wen = 1'b0;
            w_state_nxt      = ST_DIV_WAIT;
            w_cnt_nxt        = CNT_W'(DIV_LAT - 2);
          end else if (w_lu_hazard) begin
            w_ctl.pc_wen      = 1'b0;
            w_ctl.if_id_wen   = 1'b0;
            w_ctl.id_ex_flush = 1'b1;
          end
        end
        ST_DIV_WAIT: begin
          if (r_cnt == '0) begin
            w_ctl.div_done = 1'b1;
            w_state_nxt    = ST_RUN;
          end else begin
            w_ctl.pc_wen     = 1'b0;
            w_ctl.if_id_wen  = 1'b0;
            w_ctl.id_ex_wen  = 1'b0;
            w_ctl.ex_mem_wen = 1'b0;
            w_cnt_nxt        = r_cnt - CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (io_stall.mem_data_ok) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_ctl.pc_wen     = 1'b0;
            w_ctl.if_id_wen  = 1'b0;
            w_ctl.id_ex_wen  = 1'b0;
            w_ctl.ex_mem_wen = 1'b0;
          end
        end
        ST_MEM_DISCARD: begin
          w_ctl.pc_wen      = 1'b0;
          w_ctl.if_id_wen   = 1'b0;
          w_ctl.id_ex_flush = 1'b1;
          if (io_stall.mem_data_ok) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // Outputs are held low while reset is asserted.
  assign io_stall.pc_wen      = rst_n && w_ctl.pc_wen;
  assign io_stall.if_id_wen   = rst_n && w_ctl.if_id_wen;
  assign io_stall.if_id_flush = rst_n && w_ctl.if_id_flush;
  assign io_stall.id_ex_wen   = rst_n && w_ctl.id_ex_wen;
  assign io_stall.id_ex_flush = rst_n && w_ctl.id_ex_flush;
  assign io_stall.ex_mem_wen  = rst_n && w_ctl.ex_mem_wen;
  assign io_stall.bp_flush    = rst_n && w_ctl.bp_flush;
  assign io_stall.div_done    = rst_n && w_ctl.div_done;
  assign io_stall.div_cancel  = rst_n && w_ctl.div_cancel;

`ifdef STALL_PERF_CNT_EN
  logic                  w_run_free;
  logic                  w_lu_cause;
  logic                  w_div_cause;
  logic                  w_mem_cause;
  logic [PERF_CNT_W-1:0] r_lu_stall_cnt;
  logic [PERF_CNT_W-1:0] r_div_stall_cnt;
  logic [PERF_CNT_W-1:0] r_mem_stall_cnt;

  assign w_run_free  = (r_state == ST_RUN) && !io_stall.wb_flush && !w_mem_stall
                       && !io_stall.ex_br_mispred;
  assign w_lu_cause  = w_run_free && !io_stall.ex_div_start && w_lu_hazard;
  assign w_div_cause = (w_run_free && io_stall.ex_div_start)
                       || ((r_state == ST_DIV_WAIT) && !io_stall.wb_flush && (r_cnt != '0));
  assign w_mem_cause = ((r_state == ST_RUN) && !io_stall.wb_flush && w_mem_stall)
                       || ((r_state == ST_MEM_WAIT) && !io_stall.wb_flush && !io_stall.mem_data_ok)
                       || (r_state == ST_MEM_DISCARD);

  // Saturating per-cause stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_stall_cnt  <= '0;
      r_div_stall_cnt <= '0;
      r_mem_stall_cnt <= '0;
    end else begin
      if (w_lu_cause && (r_lu_stall_cnt != '1)) begin
        r_lu_stall_cnt <= r_lu_stall_cnt + PERF_CNT_W'(1);
      end
      if (w_div_cause && (r_div_stall_cnt != '1)) begin
        r_div_stall_cnt <= r_div_stall_cnt + PERF_CNT_W'(1);
      end
      if (w_mem_cause && (r_mem_stall_cnt != '1)) begin
        r_mem_stall_cnt <= r_mem_stall_cnt + PERF_CNT_W'(1);
      end
    end
  end

  assign io_stall.lu_stall_cnt  = r_lu_stall_cnt;
  assign io_stall.div_stall_cnt = r_div_stall_cnt;
  assign io_stall.mem_stall_cnt = r_mem_stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stall_ctrl.sv
// Directed bench for id_ex_stall_ctrl; control bundle compared as {pc,ifw,iff,idw,idf,exw,bp,done,cancel}.
module tb_id_ex_stall_ctrl;

  localparam logic [8:0] C_ZERO   = 9'b000000000;
  localparam logic [8:0] C_IDLE   = 9'b110101000;
  localparam logic [8:0] C_LU     = 9'b000111000;
  localparam logic [8:0] C_MISP   = 9'b111111100;
  localparam logic [8:0] C_WB     = 9'b111111000;
  localparam logic [8:0] C_CANCEL = 9'b111111001;
  localparam logic [8:0] C_DONE   = 9'b110101010;
  localparam logic [8:0] C_DISC   = 9'b000111000;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  id_ex_stall_ctrl_if bus_if ();

  id_ex_stall_ctrl #(.DIV_LAT(33), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_stall (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl();
    return {bus_if.pc_wen, bus_if.if_id_wen, bus_if.if_id_flush, bus_if.id_ex_wen,
            bus_if.id_ex_flush, bus_if.ex_mem_wen, bus_if.bp_flush, bus_if.div_done,
            bus_if.div_cancel};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clr();
    bus_if.id_reg_j      = '0;
    bus_if.id_reg_k      = '0;
    bus_if.id_reg_d      = '0;
    bus_if.id_reg_j_ren  = 1'b0;
    bus_if.id_reg_k_ren  = 1'b0;
    bus_if.id_reg_d_ren  = 1'b0;
    bus_if.ex_is_load    = 1'b0;
    bus_if.ex_reg_d      = '0;
    bus_if.ex_div_start  = 1'b0;
    bus_if.ex_br_mispred = 1'b0;
    bus_if.mem_req       = 1'b0;
    bus_if.mem_addr_ok   = 1'b0;
    bus_if.mem_data_ok   = 1'b0;
    bus_if.wb_flush      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nfrz;
    int done_at;
    int ndone;
    logic [8:0] v;

    rst_n = 1'b0;
    clr();
    bus_if.ex_is_load   = 1'b1;
    bus_if.ex_reg_d     = 5'd5;
    bus_if.id_reg_j     = 5'd5;
    bus_if.id_reg_j_ren = 1'b1;
    bus_if.wb_flush     = 1'b1;
    settle();
    check("reset_outputs", ctl(), C_ZERO);
    tick();
    clr();
    rst_n = 1'b1;
    settle();
    check("idle_after_reset", ctl(), C_IDLE);

    // Load-use on j: one bubble, then the bubble in EX clears it.
    bus_if.ex_is_load   = 1'b1;
    bus_if.ex_reg_d     = 5'd5;
    bus_if.id_reg_j     = 5'd5;
    bus_if.id_reg_j_ren = 1'b1;
    settle();
    check("lu_j_bubble", ctl(), C_LU);
    tick();
    bus_if.ex_is_load = 1'b0;
    settle();
    check("lu_resolved", ctl(), C_IDLE);
    tick();

    // Load to r0 never stalls.
    bus_if.ex_is_load = 1'b1;
    bus_if.ex_reg_d   = 5'd0;
    bus_if.id_reg_j   = 5'd0;
    settle();
    check("lu_r0_no_stall", ctl(), C_IDLE);
    tick();
    clr();

    // d source: disabled read enable ignored, enabled one stalls.
    bus_if.ex_is_load = 1'b1;
    bus_if.ex_reg_d   = 5'd7;
    bus_if.id_reg_d   = 5'd7;
    settle();
    check("lu_d_ren_off", ctl(), C_IDLE);
    tick();
    bus_if.id_reg_d_ren = 1'b1;
    settle();
    check("lu_d_ren_on", ctl(), C_LU);
    tick();
    clr();

    // Mispredict beats load-use on k.
    bus_if.ex_is_load    = 1'b1;
    bus_if.ex_reg_d      = 5'd9;
    bus_if.id_reg_k      = 5'd9;
    bus_if.id_reg_k_ren  = 1'b1;
    bus_if.ex_br_mispred = 1'b1;
    settle();
    check("misp_over_lu", ctl(), C_MISP);
    tick();
    clr();
    settle();
    check("misp_lu_after", ctl(), C_IDLE);
    tick();

    // Mispredict beats divider start.
    bus_if.ex_br_mispred = 1'b1;
    bus_if.ex_div_start  = 1'b1;
    settle();
    check("misp_over_div", ctl(), C_MISP);
    tick();
    clr();
    settle();
    check("misp_div_not_started", ctl(), C_IDLE);
    tick();

    // Full divide: 32 frozen cycles, then done with wens released.
    bus_if.ex_div_start = 1'b1;
    nfrz    = 0;
    done_at = -1;
    for (int i = 0; i < 64 && done_at < 0; i++) begin
      settle();
      v = ctl();
      if (v == C_FRZ_VAL(v)) nfrz++;
      else if (v == C_DONE) done_at = i;
      tick();
    end
    bus_if.ex_div_start = 1'b0;
    check("div_freeze_cycles", nfrz, 32);
    check("div_done_cycle", done_at, 32);
    settle();
    check("div_back_to_run", ctl(), C_IDLE);
    tick();

    // Divide cancelled by wb_flush at DIV_WAIT cycle 10.
    bus_if.ex_div_start = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    bus_if.wb_flush = 1'b1;
    settle();
    check("div_cancel_flush", ctl(), C_CANCEL);
    tick();
    clr();
    settle();
    check("div_cancel_run", ctl(), C_IDLE);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      settle();
      if (bus_if.div_done) ndone++;
    end
    check("div_cancel_no_done", ndone, 0);
    tick();

    // Data bus: response 4 cycles late.
    bus_if.mem_req     = 1'b1;
    bus_if.mem_addr_ok = 1'b1;
    nfrz = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      if (ctl() == C_ZERO) nfrz++;
      tick();
    end
    check("mem_freeze_cycles", nfrz, 4);
    bus_if.mem_data_ok = 1'b1;
    settle();
    check("mem_release", ctl(), C_IDLE);
    tick();
    clr();
    settle();
    check("mem_back_to_run", ctl(), C_IDLE);
    tick();

    // Request and response in the same cycle: no stall.
    bus_if.mem_req     = 1'b1;
    bus_if.mem_addr_ok = 1'b1;
    bus_if.mem_data_ok = 1'b1;
    settle();
    check("mem_both_ok", ctl(), C_IDLE);
    tick();
    clr();
    settle();
    check("mem_both_ok_run", ctl(), C_IDLE);
    tick();

    // wb_flush while waiting on the bus: response discarded.
    bus_if.mem_req     = 1'b1;
    bus_if.mem_addr_ok = 1'b1;
    settle();
    check("disc_frz0", ctl(), C_ZERO);
    tick();
    settle();
    check("disc_frz1", ctl(), C_ZERO);
    tick();
    bus_if.wb_flush = 1'b1;
    settle();
    check("disc_wb", ctl(), C_WB);
    tick();
    bus_if.wb_flush = 1'b0;
    nfrz = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      if (ctl() == C_DISC) nfrz++;
      tick();
    end
    check("disc_hold", nfrz, 2);
    bus_if.mem_data_ok = 1'b1;
    settle();
    check("disc_data_ok", ctl(), C_DISC);
    tick();
    clr();
    settle();
    check("disc_exit", ctl(), C_IDLE);
    tick();

    // Plain wb_flush in RUN.
    bus_if.wb_flush = 1'b1;
    settle();
    check("wb_in_run", ctl(), C_WB);
    tick();
    clr();

    // Reset in the middle of a divide.
    bus_if.ex_div_start = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    settle();
    check("rst_mid_div", ctl(), C_ZERO);
    clr();
    tick();
    rst_n = 1'b1;
    settle();
    check("rst_mid_div_run", ctl(), C_IDLE);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      settle();
      if (bus_if.div_done || bus_if.div_cancel) ndone++;
    end
    check("rst_mid_div_no_pulse", ndone, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  function automatic logic [8:0] C_FRZ_VAL(input logic [8:0] unused_v);
    logic [8:0] z;
    z = C_ZERO | (unused_v & 9'b0);
    return z;
  endfunction

endmodule
